// File: rtl/pnr_pkg.sv
// Constants and types shared by the PNR pulse emulator and the receive-side checker.
package pnr_pkg;
    localparam int DAC_W   = 14;
    localparam int SAT_LIM = 8191;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic signed [DAC_W-1:0] MARK = 14'sd4096;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/pnr_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when advance is high; seed is loaded on reset.
module pnr_lfsr16
    import pnr_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    logic [15:0] state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= seed;
        end else if (advance) begin
            state_q <= {^(state_q & LFSR_TAPS), state_q[15:1]};
        end
    end

    assign state = state_q;
endmodule

// File: rtl/pnr_pulse_emulator.sv
// Periodic detector-pulse generator: amplitude encodes a photon number, DAC_B carries a marker.
//  state | meaning
//  IDLE  | outputs held at 0, waiting for cfg_en
//  RUN   | event counter cnt steps 0 .. P-1, cnt = 0 is the event start
module pnr_pulse_emulator
    import pnr_pkg::*;
#(
    parameter int                       N_BITS = 3,
    parameter int                       DELAY  = 16,
    parameter int                       WIDTH  = 8,
    parameter int                       TRIG_W = 4,
    parameter logic signed [DAC_W-1:0]  MARK   = pnr_pkg::MARK,
    parameter logic [15:0]              SEED   = 16'hACE1
) (
    input  logic              ADC_CLK,
    input  logic              ADC_RSTN,
    input  logic              cfg_en,
    input  logic              cfg_mode,
    input  logic [15:0]       cfg_period,
    input  logic [12:0]       cfg_step,
    output logic [DAC_W-1:0]  DAC_A,
    output logic [DAC_W-1:0]  DAC_B,
    output logic              ev_stb,
    output logic [N_BITS-1:0] ev_n
);
    localparam logic [15:0] P_MIN  = 16'(DELAY + WIDTH + 1);
    localparam logic [15:0] A_LO   = 16'(DELAY);
    localparam logic [15:0] A_HI   = 16'(DELAY + WIDTH);
    localparam logic [15:0] T_HI   = 16'(TRIG_W);
    localparam int          PROD_W = (N_BITS + 13 > 16) ? N_BITS + 13 : 16;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        period_q, period_d;
    logic [12:0]        step_q, step_d;
    logic [N_BITS-1:0]  ramp_q, ramp_d;
    logic [N_BITS-1:0]  ev_n_q, ev_n_d;
    logic               ev_stb_q, ev_stb_d;
    logic [DAC_W-1:0]   dac_a_q, dac_a_d;
    logic [DAC_W-1:0]   dac_b_q, dac_b_d;

    logic               start;
    logic               lfsr_adv;
    logic [15:0]        lfsr_state;
    logic [15:0]        p_eff;
    logic [N_BITS-1:0]  ramp_base;
    logic [PROD_W-1:0]  prod;
    logic [12:0]        amp;

    pnr_lfsr16 u_lfsr (
        .clk     (ADC_CLK),
        .rstn    (ADC_RSTN),
        .advance (lfsr_adv),
        .seed    (SEED),
        .state   (lfsr_state)
    );

    assign p_eff = (period_q > P_MIN) ? period_q : P_MIN;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        step_d    = step_q;
        ramp_d    = ramp_q;
        ev_n_d    = ev_n_q;
        start     = 1'b0;
        lfsr_adv  = 1'b0;
        ramp_base = (state_q == IDLE) ? '0 : ramp_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_en) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == p_eff - 16'd1) begin
                    cnt_d = '0;
                    if (cfg_en) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Configuration is captured only here, so mid-event writes wait for the next event.
        if (start) begin
            period_d = cfg_period;
            step_d   = cfg_step;
            if (cfg_mode) begin
                ev_n_d   = lfsr_state[N_BITS-1:0];
                lfsr_adv = 1'b1;
                ramp_d   = ramp_base;
            end else begin
                ev_n_d   = ramp_base;
                ramp_d   = ramp_base + 1'b1;
            end
        end

        if (state_d == IDLE) begin
            ev_n_d = '0;
        end

        prod = PROD_W'(ev_n_d) * PROD_W'(step_d);
        amp  = (prod > PROD_W'(SAT_LIM)) ? 13'(SAT_LIM) : prod[12:0];

        dac_a_d  = (state_d == RUN && cnt_d >= A_LO && cnt_d < A_HI) ? {1'b0, amp} : '0;
        dac_b_d  = (state_d == RUN && cnt_d < T_HI) ? MARK : '0;
        ev_stb_d = start;
    end

    always_ff @(posedge ADC_CLK or negedge ADC_RSTN) begin
        if (!ADC_RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            step_q   <= '0;
            ramp_q   <= '0;
            ev_n_q   <= '0;
            ev_stb_q <= 1'b0;
            dac_a_q  <= '0;
            dac_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            step_q   <= step_d;
            ramp_q   <= ramp_d;
            ev_n_q   <= ev_n_d;
            ev_stb_q <= ev_stb_d;
            dac_a_q  <= dac_a_d;
            dac_b_q  <= dac_b_d;
        end
    end

    assign DAC_A  = dac_a_q;
    assign DAC_B  = dac_b_q;
    assign ev_stb = ev_stb_q;
    assign ev_n   = ev_n_q;
endmodule

// File: tb/tb_pnr_pulse_emulator.sv
// Directed bench for pnr_pulse_emulator: ramp, saturation, period clamp, disable, async reset, LFSR.
module tb_pnr_pulse_emulator;
    logic        clk = 1'b0;
    logic        ADC_RSTN;
    logic        cfg_en;
    logic        cfg_mode;
    logic [15:0] cfg_period;
    logic [12:0] cfg_step;
    logic [13:0] DAC_A;
    logic [13:0] DAC_B;
    logic        ev_stb;
    logic [2:0]  ev_n;

    int total = 0;
    int bad   = 0;

    logic [12:0] mid_step;
    logic [15:0] mid_period;
    logic        mid_en;
    logic [15:0] lfsr_m;

    int sat_tab[8] = '{0, 2000, 4000, 6000, 8000, 8191, 8191, 8191};

    always #5 clk = ~clk;

    pnr_pulse_emulator dut (
        .ADC_CLK    (clk),
        .ADC_RSTN   (ADC_RSTN),
        .cfg_en     (cfg_en),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_step   (cfg_step),
        .DAC_A      (DAC_A),
        .DAC_B      (DAC_B),
        .ev_stb     (ev_stb),
        .ev_n       (ev_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_stb(input int max_cyc);
        int k = 0;
        while (ev_stb !== 1'b1 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("stb_wait", 32'(ev_stb), 32'd1);
    endtask

    function automatic int amp_of(input int n, input int s);
        int p = n * s;
        return (p > 8191) ? 8191 : p;
    endfunction

    // Checks one whole event starting at the current negedge; config writes land at cnt 10.
    task automatic check_event(input int exp_n, input int exp_amp, input int p);
        for (int c = 0; c < p; c++) begin
            chk($sformatf("n%0d c%0d stb", exp_n, c), 32'(ev_stb), (c == 0) ? 32'd1 : 32'd0);
            chk($sformatf("n%0d c%0d mark", exp_n, c), 32'(DAC_B), (c < 4) ? 32'd4096 : 32'd0);
            chk($sformatf("n%0d c%0d pulse", exp_n, c), 32'(DAC_A),
                (c >= 16 && c < 24) ? 32'(exp_amp) : 32'd0);
            chk($sformatf("n%0d c%0d ev_n", exp_n, c), 32'(ev_n), 32'(exp_n));
            if (c == 10) begin
                cfg_step   = mid_step;
                cfg_period = mid_period;
                cfg_en     = mid_en;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        ADC_RSTN   = 1'b0;
        cfg_en     = 1'b0;
        cfg_mode   = 1'b0;
        cfg_period = 16'd0;
        cfg_step   = 13'd0;

        for (int i = 0; i < 6; i++) begin
            cfg_en     = 1'($urandom);
            cfg_mode   = 1'($urandom);
            cfg_period = 16'($urandom);
            cfg_step   = 13'($urandom);
            @(negedge clk);
            chk("rst dac_a", 32'(DAC_A), 32'd0);
            chk("rst dac_b", 32'(DAC_B), 32'd0);
            chk("rst stb", 32'(ev_stb), 32'd0);
            chk("rst ev_n", 32'(ev_n), 32'd0);
        end

        cfg_en     = 1'b1;
        cfg_mode   = 1'b0;
        cfg_period = 16'd32;
        cfg_step   = 13'd1000;
        mid_step   = 13'd1000;
        mid_period = 16'd32;
        mid_en     = 1'b1;
        ADC_RSTN   = 1'b1;
        @(negedge clk);
        wait_stb(5);

        for (int n = 0; n < 7; n++) check_event(n, n * 1000, 32);
        mid_step = 13'd2000;
        check_event(7, 7000, 32);
        for (int n = 0; n < 8; n++) check_event(n, sat_tab[n], 32);

        mid_period = 16'd10;
        check_event(0, 0, 32);
        check_event(1, 2000, 25);
        check_event(2, 4000, 25);

        mid_en = 1'b0;
        check_event(3, 6000, 25);
        for (int i = 0; i < 5; i++) begin
            chk("idle stb", 32'(ev_stb), 32'd0);
            chk("idle dac_a", 32'(DAC_A), 32'd0);
            chk("idle dac_b", 32'(DAC_B), 32'd0);
            chk("idle ev_n", 32'(ev_n), 32'd0);
            @(negedge clk);
        end

        mid_en = 1'b1;
        cfg_en = 1'b1;
        @(negedge clk);
        wait_stb(5);
        check_event(0, 0, 25);
        check_event(1, 2000, 25);

        chk("pre-rst stb", 32'(ev_stb), 32'd1);
        for (int c = 0; c < 18; c++) @(negedge clk);
        chk("pre-rst pulse", 32'(DAC_A), 32'd4000);
        #1 ADC_RSTN = 1'b0;
        #1;
        chk("async dac_a", 32'(DAC_A), 32'd0);
        chk("async dac_b", 32'(DAC_B), 32'd0);
        chk("async ev_n", 32'(ev_n), 32'd0);
        chk("async stb", 32'(ev_stb), 32'd0);

        cfg_mode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ADC_RSTN = 1'b1;
        @(negedge clk);
        wait_stb(5);
        chk("lfsr first", 32'(ev_n), 32'd1);

        lfsr_m = 16'hACE1;
        for (int e = 0; e < 6; e++) begin
            check_event(int'(lfsr_m[2:0]), amp_of(int'(lfsr_m[2:0]), 2000), 25);
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pnr_pulse_emulator.md
# pnr_pulse_emulator

Synthetic detector-pulse transmitter for the photon-number-resolving (PNR) signal chain: generates a periodic train of rectangular pulses whose amplitude encodes a known photon number. The pulses drive the DAC outputs, which are looped back into the ADC inputs that the PNR discriminator samples. DAC_A carries the pulse and DAC_B carries a timing marker. A per-event strobe and the emitted photon number are exported so a bench or an on-chip checker can compare them against the discriminator's decisions.

## Interface
Parameters:
- N_BITS, 3 — photon-number width; N_MAX = 2^N_BITS − 1
- DELAY, 16 — cycles from event start to pulse start
- WIDTH, 8 — pulse length in cycles
- TRIG_W, 4 — marker length in cycles
- MARK, 14'sd4096 — marker amplitude on DAC_B
- SEED, 16'hACE1 — LFSR reset value, must be nonzero

Ports:
- ADC_CLK  in  1  — sole clock; the ADC sample clock
- ADC_RSTN  in  1  — reset, asynchronous, active-low
- cfg_en  in  1  — run the pulse train
- cfg_mode  in  1  — 0 = ramp sequence, 1 = LFSR sequence
- cfg_period  in  16  — cycles per event, unsigned
- cfg_step  in  13  — amplitude per photon, unsigned
- DAC_A  out  14  — pulse output, two's complement
- DAC_B  out  14  — marker output, two's complement
- ev_stb  out  1  — one-cycle strobe at event start
- ev_n  out  N_BITS  — photon number of the current event

## Operation
- FSM states:
  - IDLE: all outputs 0.
  - RUN: event counter cnt runs 0 … P−1.
- Event start is the cycle in which cnt = 0. At event start:
  - cfg_mode, cfg_step and cfg_period are latched.
  - n is selected and ev_n is updated; ev_n holds n until the next event start.
  - ev_stb = 1.
- Configuration changes outside event start have no effect on the current event.
- Effective period P = max(cfg_period, DELAY+WIDTH+1). With default parameters the minimum is 25.
- DAC_B = MARK while cnt < TRIG_W, otherwise 0.
- DAC_A = amp while DELAY ≤ cnt < DELAY+WIDTH, otherwise 0.
- amp = min(n × cfg_step, 8191):
  - Compute the product unsigned, at least 16 bits wide.
  - Saturate to 8191. The output is never negative and never wraps.
- Ramp mode:
  - n = 0, 1, …, N_MAX, 0, … with one increment per event.
  - The ramp counter clears to 0 on every IDLE→RUN transition.
- LFSR mode:
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - n = lfsr[N_BITS−1:0], then the LFSR advances one step. It advances only at LFSR-mode event starts.
  - The LFSR is loaded with SEED on reset only and is kept across enable toggles.
- Transitions:
  - IDLE→RUN when cfg_en = 1.
  - At cnt = P−1: if cfg_en = 1, the next cycle is a new event start; otherwise the FSM goes to IDLE.
  - Dropping cfg_en mid-event never truncates a pulse or marker. The event always completes its full P cycles.
- Reset is asynchronous. On assertion:
  - All outputs go to 0 immediately, including mid-pulse.
  - FSM → IDLE, cnt = 0, ramp counter = 0, LFSR = SEED.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- If cfg_en is sampled high in IDLE at clock edge k, the first event start is the cycle following edge k. That cycle shows ev_stb = 1 and DAC_B = MARK.
- For an event start at cycle t:
  - DAC_B = MARK for cycles t … t+TRIG_W−1.
  - DAC_A = amp for cycles t+DELAY … t+DELAY+WIDTH−1.
  - The next event starts at t+P.
- Throughput is one event per P cycles, with no gap cycles between back-to-back events.

## Structure
- Shared package pnr_pkg holds:
  - DAC width (14) and saturation limit 8191.
  - The state enum {IDLE, RUN}.
  - The LFSR tap constant.
  - MARK, for reuse by the receive-side checker.
- Sub-module pnr_lfsr16: 16-bit LFSR with ports clk, rstn, advance, seed, and 16-bit state output.
- The counter, FSM, amplitude multiply/saturate and output registers live in the top module.

## Test plan
- Reset: hold ADC_RSTN low, drive random config → DAC_A = DAC_B = 0, ev_stb = 0, ev_n = 0 throughout.
- Ramp, cfg_period = 32, cfg_step = 1000:
  - ev_stb every 32 cycles.
  - ev_n = 0, 1, …, 7, 0.
  - DAC_A = 0, 1000, …, 7000 at cnt 16–23.
  - DAC_B = 4096 at cnt 0–3.
- Saturation: cfg_step = 2000 → n = 4 gives DAC_A = 8000; n = 5, 6, 7 give DAC_A = 8191.
- Period clamp: cfg_period = 10 → ev_stb spacing exactly 25 cycles; cfg_period changed mid-event takes effect only at the next event.
- Disable mid-event:
  - Drop cfg_en at cnt = 10 → the full 8-cycle pulse is still emitted, and IDLE is entered after cnt = P−1.
  - Re-enable → first event has ev_n = 0.
- Async reset and LFSR:
  - Assert ADC_RSTN at cnt = 18 → DAC_A = 0 before the next edge.
  - After release, LFSR mode gives a first ev_n = 1 (0xACE1[2:0]), and the following values match the reference LFSR model.
